// File: rtl/fifo_stream_drain.sv
// Read-side consumer for synchronous_fifo. It absorbs the FIFO's one-cycle read latency in a
// two-entry buffer and presents the words as a framed valid/ready stream.
module fifo_stream_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PKT_LEN    = 4,
  parameter int unsigned PKT_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [7:0]            beat_idx,
  output logic [PKT_CNT_W-1:0]  pkt_count
);

  localparam logic [7:0] LastIdx = 8'(PKT_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic [7:0]            beat_idx_q, beat_idx_d;
  logic [PKT_CNT_W-1:0]  pkt_count_q, pkt_count_d;
  logic                  pop;
  logic [2:0]            level;

  // Words already buffered or in flight after this cycle's pop; a new pop must keep this below 2.
  always_comb begin
    pop       = (occ_q != 2'd0) & m_ready;
    level     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_r_en = !rst_n & !fifo_empty & (level < 3'd2);
  end

  always_comb begin
    inflight_d  = fifo_r_en;
    occ_d       = level[1:0];
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    beat_idx_d  = beat_idx_q;
    pkt_count_d = pkt_count_q;
    if (inflight_q) begin
      mem_d[wr_ptr_q] = fifo_data_out;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if (beat_idx_q == LastIdx) begin
        beat_idx_d  = 8'd0;
        pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
      end else begin
        beat_idx_d  = beat_idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      beat_idx_q  <= 8'd0;
      pkt_count_q <= '0;
    end else begin
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      beat_idx_q  <= beat_idx_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_comb begin
    m_valid   = (occ_q != 2'd0);
    m_data    = mem_q[rd_ptr_q];
    m_last    = m_valid & (beat_idx_q == LastIdx);
    beat_idx  = beat_idx_q;
    pkt_count = pkt_count_q;
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: a queue-based FIFO model feeds the DUT and a word-order
// scoreboard with beat/packet arithmetic predicts every stream output each cycle.
module tb_fifo_stream_drain;

  localparam int unsigned DW   = 8;
  localparam int unsigned PLEN = 4;
  localparam int unsigned CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_r_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [7:0]    beat_idx;
  logic [CW-1:0] pkt_count;

  fifo_stream_drain #(
    .DATA_WIDTH(DW),
    .PKT_LEN   (PLEN),
    .PKT_CNT_W (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_data_out(fifo_data_out),
    .fifo_empty   (fifo_empty),
    .fifo_r_en    (fifo_r_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .beat_idx     (beat_idx),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO contents, words popped but not yet presented / presented but not yet captured,
  // and the words the DUT should be holding, in stream order.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  bit            staged_v = 0;
  logic [DW-1:0] staged_d;
  bit            pres_v = 0;
  logic [DW-1:0] pres_d;
  int            beats_m = 0;
  int            pkts_m = 0;

  int cyc = 0;
  int rens_seg, pops_seg, lasts_seg, ren_cyc, fv_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_seg();
    rens_seg  = 0;
    pops_seg  = 0;
    lasts_seg = 0;
    ren_cyc   = -1;
    fv_cyc    = -1;
  endtask

  task automatic cycle(input bit gap, input bit rdy);
    int occ;
    bit pop;
    bit exp_ren;
    bit exp_last;
    @(negedge clk);
    rst_n = 1'b0;
    if (pres_v) exp_q.push_back(pres_d);
    pres_v        = staged_v;
    pres_d        = staged_d;
    fifo_data_out = staged_v ? staged_d : DW'($urandom);
    staged_v      = 0;
    fifo_empty    = gap || (fq.size() == 0);
    m_ready       = rdy;
    #1;
    occ      = exp_q.size();
    exp_last = (occ != 0) && ((beats_m % PLEN) == PLEN - 1);
    check_eq("occ_bound", 32'(occ <= 2), 32'd1);
    check_eq("m_valid", 32'(m_valid), 32'(occ != 0));
    if (occ != 0) check_eq("m_data", 32'(m_data), 32'(exp_q[0]));
    check_eq("m_last", 32'(m_last), 32'(exp_last));
    check_eq("beat_idx", 32'(beat_idx), 32'(beats_m % PLEN));
    check_eq("pkt_count", 32'(pkt_count), 32'(pkts_m % 65536));
    pop     = (occ != 0) && rdy;
    exp_ren = !fifo_empty && (occ + int'(pres_v) - int'(pop) < 2);
    check_eq("fifo_r_en", 32'(fifo_r_en), 32'(exp_ren));
    if (pop) begin
      void'(exp_q.pop_front());
      pops_seg++;
      if (exp_last) lasts_seg++;
      beats_m++;
      if ((beats_m % PLEN) == 0) pkts_m++;
    end
    if (fifo_r_en && !fifo_empty && fq.size() != 0) begin
      staged_d = fq.pop_front();
      staged_v = 1;
    end
    if (fifo_r_en) begin
      rens_seg++;
      if (ren_cyc < 0) ren_cyc = cyc;
    end
    if (m_valid && fv_cyc < 0) fv_cyc = cyc;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n      = 1'b1;
      fifo_empty = 1'b0;
      m_ready    = 1'($urandom);
      #1;
      check_eq("rst_r_en", 32'(fifo_r_en), 32'd0);
      if (i > 0) begin
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_m_last", 32'(m_last), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        check_eq("rst_beat_idx", 32'(beat_idx), 32'd0);
        check_eq("rst_pkt_count", 32'(pkt_count), 32'd0);
      end
      cyc++;
    end
    // Anything popped from the FIFO before reset is lost along with the buffer.
    exp_q.delete();
    staged_v = 0;
    pres_v   = 0;
    beats_m  = 0;
    pkts_m   = 0;
  endtask

  initial begin
    int guard;
    fq.push_back(8'h99);
    do_reset(3);

    // Single word: two-cycle pop-to-valid latency.
    fq.delete();
    fq.push_back(8'hA5);
    clear_seg();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
    check_eq("single_rens", 32'(rens_seg), 32'd1);
    check_eq("single_latency", 32'(fv_cyc - ren_cyc), 32'd2);
    check_eq("single_beat_idx", 32'(beat_idx), 32'd1);
    check_eq("single_lasts", 32'(lasts_seg), 32'd0);

    // Burst of two packets at full throughput.
    do_reset(2);
    for (int i = 0; i < 8; i++) fq.push_back(8'(i));
    clear_seg();
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b1);
    check_eq("burst_pops", 32'(pops_seg), 32'd8);
    check_eq("burst_lasts", 32'(lasts_seg), 32'd2);
    check_eq("burst_pkt_count", 32'(pkt_count), 32'd2);
    check_eq("burst_valid_run", 32'(fv_cyc + 8), 32'(ren_cyc + 10));

    // Backpressure: only two words may be pulled while stalled.
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h10 + i));
    clear_seg();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
    check_eq("stall_rens", 32'(rens_seg), 32'd2);
    check_eq("stall_m_data", 32'(m_data), 32'h10);
    check_eq("stall_m_valid", 32'(m_valid), 32'd1);
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1);
    check_eq("stall_pops", 32'(pops_seg), 32'd8);

    // Empty gaps every other cycle; framing continues across them.
    for (int i = 0; i < 5; i++) fq.push_back(8'(8'h40 + i));
    clear_seg();
    for (int i = 0; i < 20; i++) cycle(1'(i % 2), 1'b1);
    check_eq("gap_pops", 32'(pops_seg), 32'd5);
    check_eq("gap_lasts", 32'(lasts_seg), 32'd1);
    check_eq("gap_beat_idx", 32'(beat_idx), 32'd1);

    // Reset mid-packet with a word in flight.
    do_reset(2);
    for (int i = 0; i < 6; i++) fq.push_back(8'(8'h60 + i));
    clear_seg();
    guard = 0;
    while (pops_seg < 2 && guard < 20) begin
      cycle(1'b0, 1'b1);
      guard++;
    end
    check_eq("midrst_reached", 32'(pops_seg), 32'd2);
    do_reset(1);
    clear_seg();
    cycle(1'b0, 1'b1);
    check_eq("midrst_pkt_count", 32'(pkt_count), 32'd0);
    check_eq("midrst_beat_idx", 32'(beat_idx), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(2) == 0 && fq.size() < 6) fq.push_back(DW'($urandom));
      cycle(($urandom_range(3) == 0), ($urandom_range(2) != 0));
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
    check_eq("drain_fifo", 32'(fq.size()), 32'd0);
    check_eq("drain_m_valid", 32'(m_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Read-side consumer sitting directly downstream of synchronous_fifo.
- Pops words through the FIFO's r_en/empty/data_out port and absorbs the FIFO's 1-cycle registered read latency in a 2-entry output buffer.
- Presents the words as a valid/ready stream with packet framing (last every PKT_LEN beats) and a running packet counter.

Parameters:
- DATA_WIDTH, 8, width of FIFO data_out and m_data; must match the FIFO.
- PKT_LEN, 4, beats per packet; legal range 1..256.
- PKT_CNT_W, 16, width of pkt_count.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-high: 1 = reset. Name kept for codebase consistency.
- fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_r_en.
- fifo_empty  input  1  FIFO empty flag.
- fifo_r_en  output  1  FIFO pop request.
- m_data  output  DATA_WIDTH  stream data (head of buffer).
- m_valid  output  1  stream valid.
- m_ready  input  1  downstream ready.
- m_last  output  1  marks the final beat of a packet.
- beat_idx  output  8  index of the head beat within the current packet.
- pkt_count  output  PKT_CNT_W  completed packets, wraps modulo 2^PKT_CNT_W.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values (while rst_n=1, registered):
  - fifo_r_en=0, m_valid=0, m_last=0, m_data=0.
  - beat_idx=0, pkt_count=0.
  - Buffer occupancy=0, inflight=0.
- Reset mid-operation: buffer contents and any in-flight FIFO word are discarded. The FIFO has already popped that word; this loss is accepted and documented.
- State:
  - occ: 0..2 buffered words.
  - inflight: 1 bit, equal to fifo_r_en registered.
  - 2-entry circular buffer with rd_ptr and wr_ptr (1 bit each).
- Read rule (combinational): fifo_r_en = !rst_n & !fifo_empty & ((occ + inflight - pop) < 2), where pop = m_valid & m_ready. This is the only combinational path from m_ready to fifo_r_en.
- Capture: when inflight=1, write fifo_data_out into buf[wr_ptr] and toggle wr_ptr.
- Occupancy update: occ_next = occ + inflight - pop.
- Overflow check: occ must never exceed 2. The bench asserts this.
- Output:
  - m_valid = (occ != 0).
  - m_data = buf[rd_ptr].
  - On pop, rd_ptr toggles.
- Latency:
  - fifo_r_en in cycle N → fifo_data_out valid in N+1 → captured at the end of N+1 → m_valid in N+2.
  - Minimum FIFO-pop-to-stream latency is 2 cycles.
- Throughput: with fifo_empty=0 and m_ready=1, one beat per cycle is sustained indefinitely.
- Stream rules:
  - Once m_valid=1, m_valid, m_data and m_last hold stable until pop.
  - m_valid is never deasserted without a pop.
- Framing:
  - m_last = m_valid & (beat_idx == PKT_LEN-1).
  - On pop, beat_idx increments; when it is PKT_LEN-1 it wraps to 0 and pkt_count increments (modulo 2^PKT_CNT_W).
  - PKT_LEN=1: every beat is last.
- Empty handling:
  - fifo_r_en is never asserted while fifo_empty=1.
  - A drained FIFO leaves m_valid=0 once the buffer empties.
  - Framing state (beat_idx) persists across gaps.
- Simultaneous capture and pop with occ=2 cannot occur, because the read rule prevents it.
- Simultaneous capture and pop with occ=1: occ stays 1 and both pointers toggle.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles with fifo_empty=0 → fifo_r_en=0, m_valid=0, beat_idx=0, pkt_count=0 throughout.
- Single word: FIFO holds 0xA5, m_ready=1 → fifo_r_en high 1 cycle; m_valid=1 with m_data=0xA5 exactly 2 cycles later; beat_idx then 1; m_last=0.
- Burst (PKT_LEN=4): FIFO loaded with 0x00..0x07, m_ready=1 → 8 consecutive valid beats 0x00..0x07; m_last on 0x03 and 0x07; pkt_count=2 afterwards.
- Backpressure: stream 0x10.. with m_ready=0 for 6 cycles → at most 2 FIFO pops during the stall; m_data stays 0x10 and m_valid stays 1; on release, 0x10, 0x11, 0x12 arrive in order with no loss or duplication.
- Empty gaps: FIFO empty alternates every other cycle → fifo_r_en never high while empty; no spurious m_valid; beat_idx continues across gaps (5 words give last on the 4th, then beat_idx=1).
- Reset mid-packet: after 2 beats of a packet plus 1 in flight, pulse rst_n=1 for 1 cycle → all outputs return to reset values; next word starts at beat_idx=0 with pkt_count=0.
